// File: rtl/p_instruction.sv
// p_instruction: decoded-instruction types, flag indices and condition evaluation
package p_instruction;
    typedef enum logic [2:0] {
        KIND_ALU     = 3'd0,
        KIND_LOAD    = 3'd1,
        KIND_STORE   = 3'd2,
        KIND_BRANCH  = 3'd3,
        KIND_INVALID = 3'd7
    } e_kind;

    typedef enum logic [2:0] {
        COND_AL, COND_EQ, COND_NE, COND_GT, COND_GE, COND_LT, COND_LE, COND_NV
    } e_cond;

    typedef struct packed {
        e_kind       kind;
        e_cond       cond;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rq;
        logic [15:0] imm;
    } s_decoded;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic cond_eval(input e_cond c, input logic [3:0] f);
        logic lt;
        lt = f[FLAG_N] ^ f[FLAG_V];
        cond_eval = c == COND_AL ? 1'b1 :
                    c == COND_EQ ? f[FLAG_Z] :
                    c == COND_NE ? !f[FLAG_Z] :
                    c == COND_GT ? !f[FLAG_Z] && !lt :
                    c == COND_GE ? !lt :
                    c == COND_LT ? lt :
                    c == COND_LE ? f[FLAG_Z] || lt : 1'b0;
    endfunction
endpackage

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: register/flags busy tracking with same-cycle writeback bypass
module issue_scoreboard (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_valid,
    input  logic [4:0] set_rd,
    input  logic       set_flags,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd,
    input  logic       wb_flags,
    input  logic [4:0] rd,
    input  logic [4:0] rs,
    input  logic [4:0] rq,
    input  logic       need_flags,
    output logic       hazard
);
    logic [31:0] busy, eff, set_mask;
    logic        flags_busy, flags_eff;

    assign eff       = busy & ~(wb_valid ? 32'd1 << wb_rd : 32'd0);
    assign flags_eff = flags_busy & ~wb_flags;
    // r0 is never marked, so eff[0] is always clear and needs no explicit guard
    assign set_mask  = set_valid ? (32'd1 << set_rd) & ~32'd1 : 32'd0;
    assign hazard    = eff[rd] || eff[rs] || eff[rq] || (need_flags && flags_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            flags_busy <= 1'b0;
        end else begin
            busy       <= eff | set_mask;
            flags_busy <= flags_eff | set_flags;
        end
    end
endmodule

// File: rtl/issue_stage.sv
// issue_stage: hazard-checked, condition-filtered single-entry issue register
module issue_stage
    import p_instruction::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  s_decoded   in_decoded,
    input  logic       in_sets_flags,
    input  logic [3:0] flags,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd,
    input  logic       wb_flags,
    input  logic       flush,
    output logic       out_valid,
    input  logic       out_ready,
    output s_decoded   out_decoded,
    output logic       illegal,
    output logic [15:0] stall_cnt
);
    logic hazard, accept, invalid, issue;

    assign invalid  = in_decoded.kind == KIND_INVALID;
    assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign issue    = accept && !invalid && cond_eval(in_decoded.cond, flags);

    issue_scoreboard u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_valid (issue),
        .set_rd    (in_decoded.rd),
        .set_flags (issue && in_sets_flags),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_flags  (wb_flags),
        .rd        (in_decoded.rd),
        .rs        (in_decoded.rs),
        .rq        (in_decoded.rq),
        .need_flags(in_decoded.cond != COND_AL),
        .hazard    (hazard)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_decoded <= '0;
            illegal     <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            illegal   <= accept && invalid;
            stall_cnt <= in_valid && hazard && stall_cnt != 16'hFFFF ? stall_cnt + 16'd1 : stall_cnt;
            out_valid <= flush ? 1'b0 : issue ? 1'b1 : out_ready ? 1'b0 : out_valid;
            if (issue)
                out_decoded <= in_decoded;
        end
    end
endmodule

// File: tb/tb_issue_stage.sv
// tb_issue_stage: directed scenarios with a queue of expected issued instructions
module tb_issue_stage;
    import p_instruction::*;

    logic       clk = 0, rst_n = 0, in_valid = 0, in_sets_flags = 0;
    logic       wb_valid = 0, wb_flags = 0, flush = 0, out_ready = 1;
    logic [3:0] flags = 0;
    logic [4:0] wb_rd = 0;
    logic       in_ready, out_valid, illegal;
    logic [15:0] stall_cnt;
    s_decoded   in_decoded = '0, out_decoded;
    s_decoded   exp_q[$];
    s_decoded   hold_a;
    int         n_chk = 0, n_pass = 0;

    issue_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_decoded(in_decoded), .in_sets_flags(in_sets_flags), .flags(flags),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_flags(wb_flags), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_decoded(out_decoded),
        .illegal(illegal), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic s_decoded mk(input logic [2:0] k, input logic [2:0] c,
                                    input logic [4:0] rd, input logic [4:0] rs,
                                    input logic [4:0] rq, input logic [15:0] imm);
        s_decoded d;
        d.kind = e_kind'(k);
        d.cond = e_cond'(c);
        d.rd = rd;
        d.rs = rs;
        d.rq = rq;
        d.imm = imm;
        return d;
    endfunction

    function automatic logic cond_ref(input int c, input logic [3:0] f);
        logic n, z, v;
        {n, z, v} = {f[3], f[2], f[0]};
        case (c)
            0: return 1'b1;
            1: return z;
            2: return !z;
            3: return !z && (n == v);
            4: return n == v;
            5: return n != v;
            6: return z || (n != v);
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input s_decoded d);
        in_decoded = d;
        in_valid = 1;
        #1;
    endtask

    // consumption point: execute takes out_decoded at the coming edge
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("issue_q_empty", 64'(exp_q.size()), 64'd1);
            else chk("out_decoded", 64'(out_decoded), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        #2;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_decoded", 64'(out_decoded), 0);
        chk("rst_illegal", 64'(illegal), 0);
        chk("rst_stall_cnt", 64'(stall_cnt), 0);
        @(posedge clk); #1; rst_n = 1;

        // RAW hazard on rd=3, resolved by same-cycle writeback
        offer(mk(0, 0, 3, 1, 2, 16'h11));
        chk("t1_ready", 64'(in_ready), 1);
        exp_q.push_back(in_decoded);
        tick();
        chk("t1_latency", 64'(out_valid), 1);
        offer(mk(0, 0, 4, 3, 0, 16'h22));
        chk("raw_stall", 64'(in_ready), 0);
        tick(); tick();
        chk("stall_cnt2", 64'(stall_cnt), 2);
        wb_valid = 1; wb_rd = 3; #1;
        chk("wb_bypass", 64'(in_ready), 1);
        exp_q.push_back(in_decoded);
        tick();
        wb_valid = 0; in_valid = 0;
        chk("stall_hold", 64'(stall_cnt), 2);
        chk("t1b_out_valid", 64'(out_valid), 1);
        wb_valid = 1; wb_rd = 4; tick(); wb_valid = 0;

        // flags hazard, then condition false drop
        in_sets_flags = 1;
        offer(mk(0, 0, 6, 0, 0, 16'h33));
        exp_q.push_back(in_decoded);
        tick();
        in_sets_flags = 0; flags = 4'b0000;
        offer(mk(0, 1, 7, 0, 0, 16'h44));
        chk("flag_stall", 64'(in_ready), 0);
        tick();
        chk("stall_cnt3", 64'(stall_cnt), 3);
        wb_flags = 1; #1;
        chk("flag_bypass", 64'(in_ready), 1);
        tick();
        wb_flags = 0; in_valid = 0;
        chk("cond_drop", 64'(out_valid), 0);
        offer(mk(0, 0, 0, 7, 0, 16'h45));
        chk("drop_no_busy", 64'(in_ready), 1);
        exp_q.push_back(in_decoded);
        tick();
        in_valid = 0;
        wb_valid = 1; wb_rd = 6; tick(); wb_valid = 0;

        // condition table with random flags
        for (int i = 0; i < 16; i++) begin
            flags = 4'($urandom);
            offer(mk(0, 3'(i % 8), 0, 0, 0, 16'(16'h100 + i)));
            chk("cond_ready", 64'(in_ready), 1);
            if (cond_ref(i % 8, flags)) exp_q.push_back(in_decoded);
            tick();
            chk($sformatf("cond%0d_f%0h", i % 8, flags), 64'(out_valid), 64'(cond_ref(i % 8, flags)));
        end

        // invalid kind
        offer(mk(3'b111, 0, 0, 0, 0, 16'h55));
        chk("inv_ready", 64'(in_ready), 1);
        tick();
        in_valid = 0;
        chk("illegal_pulse", 64'(illegal), 1);
        chk("inv_no_issue", 64'(out_valid), 0);
        tick();
        chk("illegal_clear", 64'(illegal), 0);

        // backpressure and back-to-back issue
        out_ready = 0;
        hold_a = mk(0, 0, 0, 0, 0, 16'h0A);
        offer(hold_a);
        exp_q.push_back(in_decoded);
        tick();
        chk("bp_valid", 64'(out_valid), 1);
        offer(mk(0, 0, 0, 0, 0, 16'h0B));
        chk("bp_ready", 64'(in_ready), 0);
        tick();
        chk("bp_hold", 64'(out_decoded), 64'(hold_a));
        chk("bp_valid2", 64'(out_valid), 1);
        out_ready = 1; #1;
        chk("bp_release", 64'(in_ready), 1);
        exp_q.push_back(in_decoded);
        tick();
        offer(mk(0, 0, 0, 0, 0, 16'h0C));
        chk("b2b_ready", 64'(in_ready), 1);
        exp_q.push_back(in_decoded);
        tick();
        chk("b2b_valid", 64'(out_valid), 1);
        offer(mk(0, 0, 0, 0, 0, 16'h0D));
        exp_q.push_back(in_decoded);
        tick();
        in_valid = 0;
        tick();
        chk("b2b_drain", 64'(out_valid), 0);

        // set wins over same-cycle clear
        wb_valid = 1; wb_rd = 5;
        offer(mk(0, 0, 5, 0, 0, 16'h05));
        chk("set_clr_ready", 64'(in_ready), 1);
        exp_q.push_back(in_decoded);
        tick();
        wb_valid = 0;
        offer(mk(0, 0, 0, 5, 0, 16'h06));
        chk("set_wins", 64'(in_ready), 0);
        tick();
        chk("stall_cnt4", 64'(stall_cnt), 4);
        wb_valid = 1; wb_rd = 5; #1;
        exp_q.push_back(in_decoded);
        tick();
        wb_valid = 0; in_valid = 0;
        tick();

        // flush
        out_ready = 0;
        offer(mk(0, 0, 0, 0, 0, 16'h77));
        exp_q.push_back(in_decoded);
        tick();
        flush = 1;
        offer(mk(0, 0, 0, 0, 0, 16'h78));
        chk("flush_ready", 64'(in_ready), 0);
        tick();
        flush = 0; in_valid = 0;
        exp_q.delete();
        chk("flush_clear", 64'(out_valid), 0);

        // async reset with pending state
        offer(mk(0, 0, 9, 0, 0, 16'h09));
        exp_q.push_back(in_decoded);
        tick();
        in_valid = 0;
        chk("pre_rst_valid", 64'(out_valid), 1);
        rst_n = 0; #1;
        chk("arst_out_valid", 64'(out_valid), 0);
        chk("arst_out_decoded", 64'(out_decoded), 0);
        chk("arst_illegal", 64'(illegal), 0);
        chk("arst_stall_cnt", 64'(stall_cnt), 0);
        exp_q.delete();
        tick();
        rst_n = 1; out_ready = 1;
        offer(mk(0, 0, 0, 9, 0, 16'h99));
        chk("post_rst_ready", 64'(in_ready), 1);
        exp_q.push_back(in_decoded);
        tick();
        in_valid = 0;
        chk("post_rst_issue", 64'(out_valid), 1);
        tick();
        chk("q_drained", 64'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
